// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives the combinational I-cache and
// buffers returned words with their PCs in a small in-order queue for decode.
// Redirects flush the queue and restart fetch at a word-aligned PC.
// Optional build macro INST_FETCH_STATS_EN adds push and stall counters.
module inst_fetch #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          INST_W   = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              icache_ce,
  output logic [ADDR_W-1:0] icache_addr,
  output logic              icache_stall,
  input  logic [INST_W-1:0] icache_inst,
  input  logic              icache_enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              deq_valid,
  output logic [INST_W-1:0] deq_inst,
  output logic [ADDR_W-1:0] deq_pc,
  input  logic              deq_ready,
  output logic              halted
`ifdef INST_FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_stalls
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StBoot, StFetch, StHalt} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];

  logic full;
  logic not_empty;
  logic fetching;
  logic push;
  logic pop;

  // Low PC bits are forced to zero on redirect, so these inputs are ignored.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Fullness is judged on the registered count only; a same-cycle pop never frees a slot.
  assign full      = (count_q == CntW'(DEPTH));
  assign not_empty = (count_q != '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: redirect wins from any state; an invalid word parks fetch in HALT
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = StFetch;
    end else begin
      unique case (state_q)
        StBoot:  state_d = StFetch;
        StFetch: if (!full && !icache_enable) state_d = StHalt;
        StHalt:  state_d = StHalt;
        default: state_d = StBoot;
      endcase
    end
  end

  // Outputs and queue handshake strobes
  always_comb begin
    fetching     = (state_q == StFetch) && !redirect_valid;
    icache_ce    = fetching;
    icache_stall = fetching && full;
    icache_addr  = pc_q;
    halted       = (state_q == StHalt);
    push         = fetching && !full && icache_enable;
    deq_valid    = not_empty && !redirect_valid;
    pop          = deq_valid && deq_ready;
    deq_inst     = not_empty ? inst_mem[rd_ptr_q] : '0;
    deq_pc       = not_empty ? pc_mem[rd_ptr_q]   : '0;
  end

  // PC, pointer and occupancy next-state
  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[ADDR_W-1:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + ADDR_W'(4);
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // PC and queue control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Queue storage; contents are masked by count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= icache_inst;
      pc_mem[wr_ptr_q]   <= pc_q;
    end
  end

`ifdef INST_FETCH_STATS_EN
  logic [31:0] stat_fetched_q;
  logic [31:0] stat_stalls_q;

  // Free-running counters; deliberately untouched by redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_fetched_q <= '0;
      stat_stalls_q  <= '0;
    end else begin
      if (push)         stat_fetched_q <= stat_fetched_q + 32'd1;
      if (icache_stall) stat_stalls_q  <= stat_stalls_q + 32'd1;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_stalls  = stat_stalls_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset, streaming, back-pressure, halt,
// redirect, PC wrap and (with INST_FETCH_STATS_EN) the statistics counters.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icache_ce;
  logic [31:0] icache_addr;
  logic        icache_stall;
  logic [31:0] icache_inst;
  logic        icache_enable;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deq_valid;
  logic [31:0] deq_inst;
  logic [31:0] deq_pc;
  logic        deq_ready;
  logic        halted;
`ifdef INST_FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stalls;
`endif

  logic        bad_en;
  logic [31:0] bad_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Cache model: word derived from address; one address can be marked invalid.
  assign icache_inst   = icache_addr ^ 32'hDEAD_BEEF;
  assign icache_enable = !(bad_en && (icache_addr == bad_addr));

  inst_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .icache_ce      (icache_ce),
    .icache_addr    (icache_addr),
    .icache_stall   (icache_stall),
    .icache_inst    (icache_inst),
    .icache_enable  (icache_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_valid      (deq_valid),
    .deq_inst       (deq_inst),
    .deq_pc         (deq_pc),
    .deq_ready      (deq_ready),
    .halted         (halted)
`ifdef INST_FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_stalls    (stat_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n          = 1'b0;
    deq_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bad_en         = 1'b0;
    bad_addr       = '0;
    #2;
    chk("rst_ce",        icache_ce,    1'b0);
    chk("rst_stall",     icache_stall, 1'b0);
    chk("rst_addr",      icache_addr,  32'h0);
    chk("rst_deq_valid", deq_valid,    1'b0);
    chk("rst_deq_inst",  deq_inst,     32'h0);
    chk("rst_deq_pc",    deq_pc,       32'h0);
    chk("rst_halted",    halted,       1'b0);

    // Streaming after reset release
    tick(); rst_n = 1'b1; #1;
    chk("boot_ce", icache_ce, 1'b0);
    chk("boot_stall", icache_stall, 1'b0);
    tick();
    chk("c2_ce", icache_ce, 1'b1);
    chk("c2_addr", icache_addr, 32'h0);
    chk("c2_deq_valid", deq_valid, 1'b0);
    tick();
    chk("c3_deq_valid", deq_valid, 1'b1);
    chk("c3_deq_pc", deq_pc, 32'h0);
    chk("c3_deq_inst", deq_inst, 32'hDEAD_BEEF);
    tick();
    chk("c4_deq_pc", deq_pc, 32'h4);
    tick();
    chk("c5_deq_pc", deq_pc, 32'h8);
    chk("c5_deq_inst", deq_inst, 32'h8 ^ 32'hDEAD_BEEF);
    chk("c5_halted", halted, 1'b0);

    // Asynchronous reset mid-stream, then back-pressure
    rst_n = 1'b0; #1;
    chk("areset_deq_valid", deq_valid, 1'b0);
    chk("areset_addr", icache_addr, 32'h0);
    deq_ready = 1'b0;
    tick(); rst_n = 1'b1; #1;
    for (int i = 0; i < 5; i++) tick();
    chk("full_stall", icache_stall, 1'b1);
    chk("full_ce", icache_ce, 1'b1);
    chk("full_addr", icache_addr, 32'h10);
    chk("full_deq_pc", deq_pc, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    chk("full_hold_stall", icache_stall, 1'b1);
    chk("full_hold_pc", deq_pc, 32'h0);
    bad_en   = 1'b1;
    bad_addr = 32'h14;
    deq_ready = 1'b1; #1;
    chk("release_stall_still", icache_stall, 1'b1);
    tick();
    chk("drain1_pc", deq_pc, 32'h4);
    chk("drain1_stall", icache_stall, 1'b0);
    chk("drain1_addr", icache_addr, 32'h10);
    tick();
    chk("drain2_pc", deq_pc, 32'h8);
    chk("drain2_addr", icache_addr, 32'h14);
    tick();
    chk("drain3_pc", deq_pc, 32'hC);
    chk("halt_flag", halted, 1'b1);
    chk("halt_ce", icache_ce, 1'b0);
    tick();
    chk("drain4_pc", deq_pc, 32'h10);
    chk("drain4_valid", deq_valid, 1'b1);
    tick();
    chk("halt_empty", deq_valid, 1'b0);
    chk("halt_stays", halted, 1'b1);

    // Redirect out of HALT, fill 3 entries, then redirect to 0x103
    deq_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40; #1;
    chk("redir0_ce", icache_ce, 1'b0);
    tick(); redirect_valid = 1'b0; #1;
    chk("redir0_halted", halted, 1'b0);
    chk("redir0_addr", icache_addr, 32'h40);
    chk("redir0_fetch_ce", icache_ce, 1'b1);
    tick(); tick(); tick();
    chk("three_queued", deq_pc, 32'h40);
    deq_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103; #1;
    chk("redir1_deq_valid", deq_valid, 1'b0);
    chk("redir1_ce", icache_ce, 1'b0);
    tick(); redirect_valid = 1'b0; #1;
    chk("redir1_addr", icache_addr, 32'h100);
    chk("redir1_empty", deq_valid, 1'b0);
    tick();
    chk("redir1_deq_valid2", deq_valid, 1'b1);
    chk("redir1_deq_pc", deq_pc, 32'h100);
    chk("redir1_deq_inst", deq_inst, 32'h100 ^ 32'hDEAD_BEEF);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8; #1;
    tick(); redirect_valid = 1'b0; #1;
    chk("wrap_addr0", icache_addr, 32'hFFFF_FFF8);
    tick();
    chk("wrap_pc0", deq_pc, 32'hFFFF_FFF8);
    tick();
    chk("wrap_pc1", deq_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc2", deq_pc, 32'h0);
    chk("wrap_valid", deq_valid, 1'b1);

`ifdef INST_FETCH_STATS_EN
    // 6 pushes and 3 full-stall cycles, then a redirect
    rst_n = 1'b0; bad_en = 1'b0; deq_ready = 1'b0; #1;
    chk("stat_rst_fetched", stat_fetched, 32'd0);
    tick(); rst_n = 1'b1; #1;
    for (int i = 0; i < 7; i++) tick();
    deq_ready = 1'b1;
    tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0; #1;
    chk("stat_fetched", stat_fetched, 32'd6);
    chk("stat_stalls", stat_stalls, 32'd3);
    tick(); redirect_valid = 1'b0; #1;
    chk("stat_fetched_redir", stat_fetched, 32'd6);
    chk("stat_stalls_redir", stat_stalls, 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
